// File: rtl/bitonic_pkg.sv
// ============================================================================
// Module : bitonic_pkg
// Brief  : Shared types, defaults and cycle-count helper for the bitonic sorter
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bitonic_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SORT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // One compare-exchange per cycle: N/2 pairs in each of lg*(lg+1)/2 stages.
  function automatic int sort_cycles(input int n);
    int lg;
    lg = $clog2(n);
    return (n / 2) * lg * (lg + 1) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bitonic_cas.sv
// ============================================================================
// Module : bitonic_cas
// Brief  : Combinational compare-exchange; lo_out gets the value bound for the
//          lower index (min when up=1, max when up=0). Equal inputs pass through.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bitonic_cas
  import bitonic_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         up,
  output logic [W-1:0] lo_out,
  output logic [W-1:0] hi_out
);

  logic w_swap;

  always_comb begin
    w_swap = up ? (a > b) : (a < b);
    lo_out = w_swap ? b : a;
    hi_out = w_swap ? a : b;
  end

endmodule

`default_nettype wire

// File: rtl/bitonic_sort_ctrl.sv
// ============================================================================
// Module : bitonic_sort_ctrl
// Brief  : Loads N words, bitonic-sorts them in place with one shared
//          compare-exchange per cycle, then streams the result out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bitonic_sort_ctrl
  import bitonic_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dir,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
);

  localparam int c_LG       = $clog2(N);
  localparam int c_PW       = (c_LG > 1) ? c_LG - 1 : 1;
  localparam int c_KW       = (c_LG > 1) ? $clog2(c_LG) : 1;
  localparam int c_SORT_LEN = sort_cycles(N);
  localparam int c_SW       = $clog2(c_SORT_LEN + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W-1:0]      r_buf [N];
  logic [c_LG-1:0]   r_wr_idx;
  logic [c_LG-1:0]   r_rd_idx;
  logic              r_dir;
  logic [c_KW-1:0]   r_kidx;      // log2(k) - 1
  logic [c_KW-1:0]   r_jexp;      // log2(j)
  logic [c_PW-1:0]   r_p;         // rank of i among indices with bit j clear
  logic [c_SW-1:0]   r_sort_cnt;
  logic              r_out_valid;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_wr_last;
  logic              w_rd_last;
  logic              w_sort_last;
  logic [c_LG:0]     w_p_ext;
  logic [c_LG:0]     w_jbit;
  logic [c_LG:0]     w_kbit;
  logic [c_LG:0]     w_lo_mask;
  logic [c_LG:0]     w_i;
  logic [c_LG-1:0]   w_i_idx;
  logic [c_LG-1:0]   w_l_idx;
  logic              w_up;
  logic [W-1:0]      w_cas_lo;
  logic [W-1:0]      w_cas_hi;

  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_wr_last   = (r_wr_idx == c_LG'(N - 1));
  assign w_rd_last   = (r_rd_idx == c_LG'(N - 1));
  assign w_sort_last = (r_sort_cnt == c_SW'(c_SORT_LEN - 1));

  // Skipped i values never cost a cycle: i is built by inserting a 0 at bit j of r_p.
  always_comb begin
    w_p_ext   = (c_LG + 1)'(r_p);
    w_jbit    = (c_LG + 1)'(1) << r_jexp;
    w_kbit    = (c_LG + 1)'(2) << r_kidx;
    w_lo_mask = w_jbit - (c_LG + 1)'(1);
    w_i       = ((w_p_ext & ~w_lo_mask) << 1) | (w_p_ext & w_lo_mask);
    w_i_idx   = w_i[c_LG-1:0];
    w_l_idx   = w_i_idx ^ w_jbit[c_LG-1:0];
    w_up      = ((w_i & w_kbit) == '0) ^ r_dir;
  end

  bitonic_cas #(
    .W(W)
  ) u_cas (
    .a      (r_buf[w_i_idx]),
    .b      (r_buf[w_l_idx]),
    .up     (w_up),
    .lo_out (w_cas_lo),
    .hi_out (w_cas_hi)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_in_fire)               w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_in_fire && w_wr_last)  w_state_nxt = ST_SORT;
      ST_SORT:  if (w_sort_last)             w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_out_fire && w_rd_last) w_state_nxt = ST_IDLE;
      default:                               w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    busy      = (r_state != ST_IDLE);
    out_valid = r_out_valid;
    out_last  = r_out_valid && w_rd_last;
    out_data  = r_out_valid ? r_buf[r_rd_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_dir       <= 1'b0;
      r_kidx      <= '0;
      r_jexp      <= '0;
      r_p         <= '0;
      r_sort_cnt  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_in_fire) begin
        if (r_state == ST_IDLE) r_dir <= dir;
        r_wr_idx <= w_wr_last ? '0 : r_wr_idx + 1'b1;
      end

      if (r_state == ST_SORT) begin
        if (w_sort_last) begin
          r_sort_cnt <= '0;
          r_kidx     <= '0;
          r_jexp     <= '0;
          r_p        <= '0;
        end else begin
          r_sort_cnt <= r_sort_cnt + 1'b1;
          if (r_p == c_PW'(N / 2 - 1)) begin
            r_p <= '0;
            if (r_jexp == '0) begin
              r_kidx <= r_kidx + 1'b1;
              r_jexp <= r_kidx + 1'b1;
            end else begin
              r_jexp <= r_jexp - 1'b1;
            end
          end else begin
            r_p <= r_p + 1'b1;
          end
        end
      end

      // The first DRAIN cycle only raises out_valid; words then stream from r_rd_idx.
      if (w_out_fire) begin
        if (w_rd_last) begin
          r_rd_idx    <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_rd_idx <= r_rd_idx + 1'b1;
        end
      end else if (r_state == ST_DRAIN) begin
        r_out_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_in_fire) begin
        r_buf[r_wr_idx] <= in_data;
      end else if (r_state == ST_SORT) begin
        r_buf[w_i_idx] <= w_cas_lo;
        r_buf[w_l_idx] <= w_cas_hi;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bitonic_sort_ctrl.sv
// ============================================================================
// Module : tb_bitonic_sort_ctrl
// Brief  : Self-checking bench; expected output is the block sorted by queue
//          sort/rsort, plus handshake, latency and reset behaviour checks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bitonic_sort_ctrl;

  localparam int N   = 8;
  localparam int W   = 32;
  localparam int LG  = $clog2(N);
  localparam int LAT = N + (N / 2) * LG * (LG + 1) / 2 + 1;

  typedef logic [W-1:0] blk_t [N];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dir;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int blk_id = 0;

  // Monitor-owned per-block observations, cleared whenever blk_id changes.
  int           mon_blk = 0;
  int           acc_cnt = 0;
  int           first_acc = -1;
  int           first_ov = -1;
  int           ready_viol = 0;
  logic [W:0]   out_q [$];

  bitonic_sort_ctrl #(
    .N(N),
    .W(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dir       (dir),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_blk != blk_id) begin
      mon_blk    = blk_id;
      acc_cnt    = 0;
      first_acc  = -1;
      first_ov   = -1;
      ready_viol = 0;
      out_q.delete();
    end
    if (rst_n) begin
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && in_ready) ready_viol++;
      if (out_valid && out_ready) out_q.push_back({out_last, out_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input blk_t vals, input bit d, input bit toggle,
                            input int gap_max, input bit hold);
    int t;
    blk_id++;
    dir = d;
    for (int w = 0; w < N; w++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int c = 0; c < g; c++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        tick();
      end
      in_valid = 1'b1;
      in_data  = vals[w];
      t = 0;
      while (!in_ready && t < 200) begin
        tick();
        t++;
      end
      check_eq("in_ready_load", in_ready, 1);
      if (!in_ready) begin
        in_valid = 1'b0;
        return;
      end
      tick();
      if (toggle && w == 2) dir = ~d;
    end
    in_valid = hold;
    in_data  = $urandom;
  endtask

  task automatic recv_block(input blk_t vals, input bit d, input int stall_at,
                            input bit chk_lat, input string tag);
    bit [W-1:0]   q [$];
    logic [W-1:0] held;
    int           t;
    int           st;
    for (int w = 0; w < N; w++) q.push_back(vals[w]);
    if (d) q.rsort();
    else   q.sort();
    t    = 0;
    st   = 0;
    held = '0;
    while (out_q.size() < N && t < 400) begin
      if (stall_at >= 0 && out_q.size() == stall_at && out_valid && st < 3) begin
        if (st == 0) held = out_data;
        else         check_eq({tag, "_hold"}, out_data, held);
        out_ready = 1'b0;
        st++;
      end else begin
        if (st == 3) begin
          check_eq({tag, "_hold"}, out_data, held);
          st = 4;
        end
        out_ready = 1'b1;
      end
      tick();
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq({tag, "_beats"}, out_q.size(), N);
    for (int b = 0; b < N && b < out_q.size(); b++)
      check_eq(tag, out_q[b], {(b == N - 1), q[b]});
    check_eq({tag, "_accepted"}, acc_cnt, N);
    check_eq({tag, "_in_ready_drain"}, ready_viol, 0);
    if (chk_lat) check_eq({tag, "_latency"}, first_ov - first_acc, LAT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    blk_t v;
    rst_n     = 1'b0;
    dir       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    v = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd8, 32'd2, 32'd6, 32'd5};
    send_block(v, 1'b0, 1'b0, 0, 1'b0);
    recv_block(v, 1'b0, -1, 1'b1, "asc");

    send_block(v, 1'b1, 1'b1, 0, 1'b0);
    recv_block(v, 1'b1, -1, 1'b1, "desc_toggle");

    v = '{32'd4, 32'd4, 32'd0, 32'hFFFF_FFFF, 32'd4, 32'd0, 32'd1, 32'd1};
    send_block(v, 1'b0, 1'b0, 0, 1'b0);
    recv_block(v, 1'b0, -1, 1'b1, "dup");

    v = '{32'd10, 32'd80, 32'd30, 32'd70, 32'd20, 32'd60, 32'd40, 32'd50};
    send_block(v, 1'b0, 1'b0, 0, 1'b0);
    recv_block(v, 1'b0, 4, 1'b1, "stall");

    // Reset pulse in the middle of SORT discards the block.
    send_block(v, 1'b1, 1'b0, 0, 1'b0);
    repeat (10) tick();
    check_eq("mid_sort_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_out_valid", out_valid, 0);
    check_eq("post_rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    repeat (40) tick();
    check_eq("post_rst_no_beats", out_q.size(), 0);
    v = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd1, 32'd2, 32'd3, 32'd4};
    send_block(v, 1'b0, 1'b0, 0, 1'b0);
    recv_block(v, 1'b0, -1, 1'b1, "post_rst");

    // in_valid held high through SORT/DRAIN, then a back-to-back block.
    for (int w = 0; w < N; w++) v[w] = $urandom;
    send_block(v, 1'b0, 1'b0, 0, 1'b1);
    recv_block(v, 1'b0, -1, 1'b1, "hold_valid");
    for (int w = 0; w < N; w++) v[w] = $urandom;
    send_block(v, 1'b1, 1'b0, 0, 1'b1);
    recv_block(v, 1'b1, 2, 1'b1, "back_to_back");

    for (int b = 0; b < 16; b++) begin
      bit d;
      bit tg;
      bit hold;
      int gm;
      int sa;
      for (int w = 0; w < N; w++)
        v[w] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      d    = 1'($urandom_range(0, 1));
      tg   = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      gm   = ($urandom_range(0, 1) == 1) ? 2 : 0;
      sa   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1;
      send_block(v, d, tg, gm, hold);
      recv_block(v, d, sa, (gm == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
